// File: rtl/game_pkg.sv
// Shared definitions for the packed game-row bus: cell codes, row geometry
// and the cell-code to GRB palette used by the LED row driver.
package game_pkg;

  localparam int CELLS    = 8;
  localparam int DATA_LEN = 5;
  localparam int ROW_W    = CELLS * DATA_LEN;
  localparam int PIXEL_W  = 24;

  localparam logic [DATA_LEN-1:0] DARK     = 5'd31;
  localparam logic [DATA_LEN-1:0] R_PLAYER = 5'd10;
  localparam logic [DATA_LEN-1:0] G_PLAYER = 5'd11;
  localparam logic [DATA_LEN-1:0] B_PLAYER = 5'd12;

  // Colors are {G, R, B}, the on-wire order of WS2812-style strips.
  localparam logic [PIXEL_W-1:0] GRB_DARK  = 24'h000000;
  localparam logic [PIXEL_W-1:0] GRB_RED   = 24'h002000;
  localparam logic [PIXEL_W-1:0] GRB_GREEN = 24'h200000;
  localparam logic [PIXEL_W-1:0] GRB_BLUE  = 24'h000020;
  localparam logic [PIXEL_W-1:0] GRB_GREY  = 24'h101010;

  function automatic logic [PIXEL_W-1:0] decode_color(input logic [DATA_LEN-1:0] code);
    case (code)
      DARK:     decode_color = GRB_DARK;
      R_PLAYER: decode_color = GRB_RED;
      G_PLAYER: decode_color = GRB_GREEN;
      B_PLAYER: decode_color = GRB_BLUE;
      default:  decode_color = GRB_GREY;
    endcase
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Times one NRZ bit: dout high for the 0/1 high time, low for the rest of the
// bit period. A start on the bit_end cycle chains the next bit with no gap.
module led_bit_timer #(
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80,
  parameter int BIT_CYCLES = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_value,
  output logic dout,
  output logic bit_end
);

  localparam logic [6:0] LAST_CNT = 7'(BIT_CYCLES - 1);
  localparam logic [6:0] T0H      = 7'(T0H_CYCLES);
  localparam logic [6:0] T1H      = 7'(T1H_CYCLES);

  logic       active;
  logic [6:0] cnt;
  logic [6:0] cnt_inc;
  logic [6:0] high_len;

  assign cnt_inc  = cnt + 7'd1;
  assign high_len = bit_value ? T1H : T0H;
  assign bit_end  = active && (cnt == LAST_CNT);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      dout   <= 1'b1;
    end else if (bit_end) begin
      active <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (active) begin
      cnt  <= cnt_inc;
      dout <= (cnt_inc < high_len);
    end
  end

endmodule

// File: rtl/row_led_driver.sv
// Accepts one packed 8-cell row, palette-decodes each cell and streams the
// pixels as a WS2812-style NRZ bit train followed by a latch gap.
module row_led_driver
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int BIT_CYCLES   = 125,
  parameter int LATCH_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_in,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             dout,
  output logic             busy,
  output logic             frame_done
);

  if (CLK_HZ <= 0 || BIT_CYCLES > 128 || LATCH_CYCLES > 8192 ||
      T0H_CYCLES < 1 || T1H_CYCLES >= BIT_CYCLES) begin : g_param_check
    $error("row_led_driver: timing parameters out of range");
  end

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  localparam logic [12:0] LATCH_LAST = 13'(LATCH_CYCLES - 1);
  localparam logic [2:0]  LAST_CELL  = 3'(CELLS - 1);
  localparam logic [4:0]  TOP_BIT    = 5'(PIXEL_W - 1);

  state_t               state;
  state_t               state_next;
  logic [ROW_W-1:0]     row_q;
  logic [PIXEL_W-1:0]   pixel;
  logic [2:0]           cell_idx;
  logic [2:0]           cell_next;
  logic [4:0]           bit_idx;
  logic [12:0]          latch_cnt;
  logic [DATA_LEN-1:0]  next_code;
  logic                 accept;
  logic                 bit_end;
  logic                 last_bit;
  logic                 cell_end;
  logic                 latch_end;
  logic                 timer_start;

  assign accept      = (state == IDLE) && row_valid;
  assign cell_next   = cell_idx + 3'd1;
  assign next_code   = row_q[DATA_LEN*cell_next +: DATA_LEN];
  assign cell_end    = (state == SEND) && bit_end && (bit_idx == 5'd0);
  assign last_bit    = (bit_idx == 5'd0) && (cell_idx == LAST_CELL);
  assign latch_end   = (state == LATCH) && (latch_cnt == LATCH_LAST);
  assign timer_start = accept || ((state == SEND) && bit_end && !last_bit);

  led_bit_timer #(
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start),
    .bit_value(pixel[bit_idx]),
    .dout     (dout),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (row_valid) state_next = SEND;
      SEND:    if (bit_end && last_bit) state_next = LATCH;
      LATCH:   if (latch_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: row_q and pixel are pure data, only consumed in SEND after a load,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q <= row_in;
      pixel <= decode_color(row_in[DATA_LEN-1:0]);
    end else if (cell_end && (cell_idx != LAST_CELL)) begin
      pixel <= decode_color(next_code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_idx   <= '0;
      bit_idx    <= '0;
      latch_cnt  <= '0;
      row_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        cell_idx <= '0;
        bit_idx  <= TOP_BIT;
      end else if ((state == SEND) && bit_end) begin
        if (bit_idx != 5'd0) begin
          bit_idx <= bit_idx - 5'd1;
        end else if (cell_idx != LAST_CELL) begin
          cell_idx <= cell_next;
          bit_idx  <= TOP_BIT;
        end
      end
      // Counter is held at zero outside LATCH so the gap always starts fresh.
      latch_cnt  <= ((state == LATCH) && !latch_end) ? latch_cnt + 13'd1 : '0;
      row_ready  <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
      frame_done <= latch_end;
    end
  end

endmodule
